sha256_arbiter: RTL and testbench
=================================

# sha256_arbiter

Round-robin arbiter that shares one `sha256` compression core among `num_req_p` requesters, each submitting multi-block messages. A grant is held for a whole message. The arbiter generates `new_hash` on the first block, silently drains intermediate per-block digests, and routes only the final digest back to the owning requester. It sits between the PBKDF2/HMAC iteration engines and the single `sha256` instance.

## Interface
Parameters:
- `num_req_p`, 2: number of requesters, ≥2.
- `lg_num_req_lp`, `$clog2(num_req_p)`: requester id width (localparam).

Ports (one clock; reset is synchronous and active-low):
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  synchronous active-low reset. The top-level drives the core's `rst_i` with `~rst_ni`.
- `req_v_i`  in  `num_req_p`  requester block valid.
- `req_last_i`  in  `num_req_p`  block is the final block of its message.
- `req_data_i`  in  `num_req_p`×512  padded message block per requester.
- `req_ready_o`  out  `num_req_p`  block accepted (handshake = `v & ready`).
- `resp_v_o`  out  `num_req_p`  final digest valid, one-hot.
- `resp_data_o`  out  256  final digest, shared bus.
- `resp_ready_i`  in  `num_req_p`  requester accepts digest.
- `core_v_o`, `core_new_hash_o`, `core_data_o[511:0]`  out  to core `in_valid`, `new_hash`, `in`.
- `core_ready_i`  in  1  core `in_ready`.
- `core_v_i`, `core_data_i[255:0]`  in  core `out_valid`, `out`.
- `core_yumi_o`  out  1  to core `out_ready`.
- `busy_o`  out  1  state ≠ IDLE.
- `grant_id_o`  out  `lg_num_req_lp`  current owner; valid when `busy_o` = 1.

## Operation
- **States:** IDLE, SEND, WAIT.
- **IDLE:**
  - If any `req_v_i` is set, choose the first set bit at or after `rr_ptr_r` (circular). Latch `grant_r`, set `first_r` = 1, go to SEND.
  - Otherwise stay in IDLE.
- **SEND:**
  - `core_v_o` = `req_v_i[grant_r]`; `core_data_o` = `req_data_i[grant_r]`; `core_new_hash_o` = `first_r`.
  - `req_ready_o[grant_r]` = `core_ready_i`. All other `req_ready_o` bits are 0.
  - On handshake: `first_r` ← 0, `last_r` ← `req_last_i[grant_r]`, go to WAIT.
- **WAIT, `last_r` = 0:** `core_yumi_o` = 1. When `core_v_i` is set, discard the intermediate digest and return to SEND.
- **WAIT, `last_r` = 1:**
  - `resp_v_o[grant_r]` = `core_v_i`; `resp_data_o` = `core_data_i`; `core_yumi_o` = `resp_ready_i[grant_r]`.
  - On handshake: `rr_ptr_r` ← `grant_r`+1 (wrapping to 0 at `num_req_p`), go to IDLE.
- Non-granted requesters see `req_ready_o` = 0 and `resp_v_o` = 0 at all times.
- A requester may deassert `req_v_i` between blocks. The grant is still held and the arbiter waits in SEND indefinitely.
- A one-block message has `req_last_i` = 1 on its first block. That block carries `new_hash` = 1 and its digest goes directly to the requester.

## Timing
- **Reset:** state = IDLE, `rr_ptr_r` = 0, `grant_r` = 0, `first_r` = 0, `last_r` = 0. Every output is 0 except the data buses, which are don't-care.
- **Arbitration:** one cycle, IDLE→SEND. The earliest `core_v_o` is the cycle after `req_v_i` rises.
- **Core handshakes:** `core_v_o`/`core_ready_i` and `core_v_i`/`core_yumi_o` are combinational pass-throughs. No added latency per block beyond the core's own.
- **Throughput overhead:** one IDLE cycle between consecutive messages.
- **Grant stability:** a request arriving mid-message does not pre-empt the owner. A simultaneous request from all requesters is granted in circular order starting at `rr_ptr_r`.
- **Reset mid-message:** returns to IDLE on the next edge and drops the message. No `resp_v_o` is issued. The core is reset in the same cycle.
- **Core output in SEND:** `core_v_i` asserted while in SEND is a protocol error. The arbiter ignores it (`core_yumi_o` = 0).

## Structure
- A shared package `sha256_pkg` holds:
  - `arb_state_e` {IDLE, SEND, WAIT};
  - block and digest width constants (512, 256).
- One natural sub-module, `rr_picker`: combinational circular priority select of a `num_req_p` vector from a pointer. It returns a one-hot grant and the binary id.
- `sha256_arbiter` contains the FSM, registers and muxes only.

## Test plan
- **Single-block, single requester:** requester 0 sends padded "abc" with `last` = 1.
  - `core_new_hash_o` = 1.
  - `resp_v_o` = 01 with `resp_data_o` = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- **Two-block message:** requester 1 sends the 56-byte "abcdbcdecdef…nopq" message.
  - `new_hash` = 1, then 0.
  - The intermediate digest is drained and no `resp_v_o` is issued for it.
  - Final `resp_data_o` = 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- **Contention:** both requesters raise `req_v_i` in the same cycle after reset.
  - Requester 0 is granted first, requester 1 second.
  - Repeat: requester 0 is granted first again (pointer wrapped to 0).
- **No pre-emption:** requester 1 asserts `req_v_i` mid-way through requester 0's two-block message. `req_ready_o[1]` stays 0 until requester 0's digest handshake completes.
- **Backpressure:** hold `resp_ready_i[0]` = 0 for 10 cycles.
  - `resp_v_o[0]`, `resp_data_o` and `core_yumi_o` = 0 stay stable.
  - The FSM stays in WAIT.
- **Reset mid-message:** pulse `rst_ni` low for 1 cycle after the first block of a two-block message. Next cycle: `busy_o` = 0 and all outputs are 0. A new "abc" message then yields the correct digest.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared types and widths for the SHA-256 core arbiter.
package sha256_pkg;

  localparam int unsigned block_w_lp  = 512;
  localparam int unsigned digest_w_lp = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sha256_arbiter_rr_picker.sv
// Circular priority select: first set request at or after the pointer, as one-hot and id.
module rr_picker #(
  parameter  int num_req_p     = 2,
  localparam int lg_num_req_lp = $clog2(num_req_p)
) (
  input  logic [num_req_p-1:0]     req_i,
  input  logic [lg_num_req_lp-1:0] ptr_i,
  output logic [num_req_p-1:0]     grant_o,
  output logic [lg_num_req_lp-1:0] id_o
);

  // Walk from the farthest offset back to the pointer so the nearest requester overwrites last.
  always_comb begin
    int idx;
    grant_o = '0;
    id_o    = '0;
    idx     = 0;
    for (int k = num_req_p - 1; k >= 0; k--) begin
      idx     = (int'(ptr_i) + k) % num_req_p;
      grant_o = req_i[idx] ? (num_req_p'(1) << idx) : grant_o;
      id_o    = req_i[idx] ? lg_num_req_lp'(idx) : id_o;
    end
  end

endmodule

// File: rtl/sha256_arbiter.sv
// Round-robin owner of a single SHA-256 core: holds the grant for a whole message,
// drains intermediate digests and returns only the final one to the requester.
module sha256_arbiter
  import sha256_pkg::*;
#(
  parameter  int num_req_p     = 2,
  localparam int lg_num_req_lp = $clog2(num_req_p)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [num_req_p-1:0]                req_v_i,
  input  logic [num_req_p-1:0]                req_last_i,
  input  logic [num_req_p-1:0][block_w_lp-1:0] req_data_i,
  output logic [num_req_p-1:0]                req_ready_o,
  output logic [num_req_p-1:0]                resp_v_o,
  output logic [digest_w_lp-1:0]              resp_data_o,
  input  logic [num_req_p-1:0]                resp_ready_i,
  output logic                                core_v_o,
  output logic                                core_new_hash_o,
  output logic [block_w_lp-1:0]               core_data_o,
  input  logic                                core_ready_i,
  input  logic                                core_v_i,
  input  logic [digest_w_lp-1:0]              core_data_i,
  output logic                                core_yumi_o,
  output logic                                busy_o,
  output logic [lg_num_req_lp-1:0]            grant_id_o
);

  localparam logic [lg_num_req_lp-1:0] last_id_lp = lg_num_req_lp'(num_req_p - 1);

  arb_state_e               state_q, state_d;
  logic [lg_num_req_lp-1:0] rr_ptr_q, rr_ptr_d;
  logic [lg_num_req_lp-1:0] grant_q, grant_d;
  logic                     first_q, first_d;
  logic                     last_q, last_d;
  logic [num_req_p-1:0]     pick_grant;
  logic [lg_num_req_lp-1:0] pick_id;

  rr_picker #(.num_req_p(num_req_p)) picker (
    .req_i   (req_v_i),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant),
    .id_o    (pick_id)
  );

  // Core and requester muxes; handshakes pass straight through so no latency is added per block.
  always_comb begin
    req_ready_o     = '0;
    resp_v_o        = '0;
    core_v_o        = 1'b0;
    core_new_hash_o = 1'b0;
    core_yumi_o     = 1'b0;
    core_data_o     = req_data_i[grant_q];
    resp_data_o     = core_data_i;
    case (state_q)
      SEND: begin
        core_v_o             = req_v_i[grant_q];
        core_new_hash_o      = first_q;
        req_ready_o[grant_q] = core_ready_i;
      end
      WAIT: begin
        if (last_q) begin
          resp_v_o[grant_q] = core_v_i;
          core_yumi_o       = resp_ready_i[grant_q];
        end else begin
          core_yumi_o = 1'b1;
        end
      end
      default: begin
        core_yumi_o = 1'b0;
      end
    endcase
  end

  // Next-state logic; the grant only moves on after the final digest is handed over.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    first_d  = first_q;
    last_d   = last_q;
    case (state_q)
      IDLE: begin
        if (|pick_grant) begin
          grant_d = pick_id;
          first_d = 1'b1;
          state_d = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (core_v_o && core_ready_i) begin
          first_d = 1'b0;
          last_d  = req_last_i[grant_q];
          state_d = WAIT;
        end else begin
          state_d = SEND;
        end
      end
      WAIT: begin
        if (core_v_i && core_yumi_o) begin
          if (last_q) begin
            rr_ptr_d = (grant_q == last_id_lp) ? '0 : grant_q + lg_num_req_lp'(1);
            state_d  = IDLE;
          end else begin
            state_d = SEND;
          end
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      first_q  <= first_d;
      last_q   <= last_d;
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign grant_id_o = grant_q;

endmodule

// File: tb/tb_sha256_arbiter.sv
// Bench for sha256_arbiter: behavioural SHA-256 core, directed requesters and a digest scoreboard.
module tb_sha256_arbiter;
  import sha256_pkg::*;

  localparam int n_lp = 2;

  localparam logic [255:0] h0_c      = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [511:0] abc_blk_c = {32'h61626380, 416'h0, 64'h18};
  localparam logic [511:0] two0_blk_c = 512'h6162636462636465636465666465666765666768666768696768696a68696a6b696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f6d6e6f706e6f70718000000000000000;
  localparam logic [511:0] two1_blk_c = {480'h0, 32'h1c0};
  localparam logic [255:0] abc_dig_c = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] two_dig_c = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [31:0] k_c [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic                       clk = 1'b0;
  logic                       rst_ni;
  logic [n_lp-1:0]            req_v_i, req_last_i, req_ready_o, resp_v_o, resp_ready_i;
  logic [n_lp-1:0][511:0]     req_data_i;
  logic [255:0]               resp_data_o, core_data_i;
  logic                       core_v_o, core_new_hash_o, core_ready_i, core_v_i, core_yumi_o, busy_o;
  logic [511:0]               core_data_o;
  logic [0:0]                 grant_id_o;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int           id;
    logic [255:0] dig;
  } exp_t;
  exp_t exp_q[$];
  time  resp_time[n_lp];
  time  acc_time[n_lp];

  always #5 clk = ~clk;

  sha256_arbiter #(.num_req_p(n_lp)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_v_i(req_v_i), .req_last_i(req_last_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .resp_ready_i(resp_ready_i),
    .core_v_o(core_v_o), .core_new_hash_o(core_new_hash_o), .core_data_o(core_data_o),
    .core_ready_i(core_ready_i), .core_v_i(core_v_i), .core_data_i(core_data_i),
    .core_yumi_o(core_yumi_o), .busy_o(busy_o), .grant_id_o(grant_id_o)
  );

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + k_c[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    r = {a, b, c, d, e, f, g, h};
    for (int j = 0; j < 8; j++) r[255 - 32*j -: 32] = r[255 - 32*j -: 32] + hin[255 - 32*j -: 32];
    return r;
  endfunction

  // Behavioural core: accepts a block when idle, presents the digest a few cycles later until taken.
  logic [255:0] core_h;
  logic         core_busy;
  int           core_cnt;
  always @(posedge clk) begin
    if (!rst_ni) begin
      core_busy <= 1'b0; core_v_i <= 1'b0; core_h <= '0; core_cnt <= 0;
    end else if (!core_busy) begin
      if (core_v_o) begin
        core_h    <= sha_compress(core_new_hash_o ? h0_c : core_h, core_data_o);
        core_busy <= 1'b1;
        core_cnt  <= 3;
      end
    end else if (!core_v_i) begin
      if (core_cnt == 0) core_v_i <= 1'b1;
      else core_cnt <= core_cnt - 1;
    end else if (core_yumi_o) begin
      core_v_i  <= 1'b0;
      core_busy <= 1'b0;
    end
  end
  assign core_ready_i = !core_busy;
  assign core_data_i  = core_h;

  task automatic check(input string nm, input logic [511:0] got, input logic [511:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, got, want);
    end
  endtask

  // Monitor: grant isolation every cycle, and digest scoreboard on each response handshake.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_ni) begin
      for (int i = 0; i < n_lp; i++) begin
        if (!busy_o || int'(grant_id_o) != i) begin
          check("isolate_ready", req_ready_o[i], 1'b0);
          check("isolate_resp", resp_v_o[i], 1'b0);
        end
      end
      if (resp_v_o != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", resp_v_o, 2'b00);
        end else if ((resp_v_o & resp_ready_i) != 2'b00) begin
          e = exp_q.pop_front();
          check("resp_owner", resp_v_o, 2'b01 << e.id);
          check("resp_digest", resp_data_o, e.dig);
          resp_time[e.id] = $time;
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that completes the handshake.
  task automatic send_block(input int id, input logic [511:0] d, input logic l, input logic nh);
    int n = 0;
    req_data_i[id] = d;
    req_last_i[id] = l;
    req_v_i[id]    = 1'b1;
    @(negedge clk);
    while (!req_ready_o[id] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("blk_ready", req_ready_o[id], 1'b1);
    if (req_ready_o[id]) begin
      check("blk_core_v", core_v_o, 1'b1);
      check("blk_new_hash", core_new_hash_o, nh);
      check("blk_data", core_data_o, d);
      acc_time[id] = $time;
    end
    @(posedge clk); #1;
    req_v_i[id] = 1'b0;
  endtask

  task automatic send_msg(input int id, input int nb, input logic [511:0] b0, input logic [511:0] b1);
    send_block(id, b0, (nb == 1), 1'b1);
    if (nb == 2) send_block(id, b1, 1'b1, 1'b0);
  endtask

  task automatic push_exp(input int id, input logic [255:0] dig);
    exp_t e;
    e.id = id; e.dig = dig;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy_o) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain_busy", busy_o, 1'b0);
    check("drain_queue", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_quiet(input string nm);
    check({nm, "_busy"}, busy_o, 1'b0);
    check({nm, "_ready"}, req_ready_o, 2'b00);
    check({nm, "_resp_v"}, resp_v_o, 2'b00);
    check({nm, "_core_v"}, core_v_o, 1'b0);
    check({nm, "_new_hash"}, core_new_hash_o, 1'b0);
    check({nm, "_yumi"}, core_yumi_o, 1'b0);
    check({nm, "_grant"}, grant_id_o, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst_ni = 1'b0; req_v_i = '0; req_last_i = '0; req_data_i = '0; resp_ready_i = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(negedge clk);
    check_quiet("post_reset");
    @(posedge clk); #1;

    // Contention twice: requester 0 must win both rounds.
    for (int r = 0; r < 2; r++) begin
      push_exp(0, abc_dig_c);
      push_exp(1, abc_dig_c);
      fork
        send_msg(0, 1, abc_blk_c, abc_blk_c);
        send_msg(1, 1, abc_blk_c, abc_blk_c);
      join
      wait_idle();
    end

    push_exp(0, abc_dig_c);
    send_msg(0, 1, abc_blk_c, abc_blk_c);
    wait_idle();

    push_exp(1, two_dig_c);
    send_msg(1, 2, two0_blk_c, two1_blk_c);
    wait_idle();

    // No pre-emption: requester 1 arrives while requester 0 is mid-message.
    push_exp(0, two_dig_c);
    push_exp(1, abc_dig_c);
    fork
      send_msg(0, 2, two0_blk_c, two1_blk_c);
      begin
        repeat (3) @(posedge clk);
        #1;
        send_msg(1, 1, abc_blk_c, abc_blk_c);
      end
    join
    wait_idle();
    check("no_preempt", acc_time[1] > resp_time[0], 1'b1);

    // Response backpressure: digest must be held stable while requester 0 stalls.
    resp_ready_i = 2'b10;
    push_exp(0, abc_dig_c);
    send_msg(0, 1, abc_blk_c, abc_blk_c);
    n = 0;
    @(negedge clk);
    while (!resp_v_o[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_resp_seen", resp_v_o[0], 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_resp_v", resp_v_o, 2'b01);
      check("bp_resp_data", resp_data_o, abc_dig_c);
      check("bp_yumi", core_yumi_o, 1'b0);
      check("bp_busy", busy_o, 1'b1);
    end
    @(posedge clk); #1;
    resp_ready_i = 2'b11;
    wait_idle();

    // Reset after the first block of a two-block message drops it entirely.
    send_block(0, two0_blk_c, 1'b0, 1'b1);
    rst_ni = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(negedge clk);
    check_quiet("mid_reset");
    @(posedge clk); #1;
    push_exp(0, abc_dig_c);
    send_msg(0, 1, abc_blk_c, abc_blk_c);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
